// File: rtl/schroeder_reverb_engine_if.sv
// Sample/config bus of the Schroeder reverb engine.
// The master side drives configuration and input samples; the slave side is the engine.
interface schroeder_reverb_engine_if #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 8
);
    localparam int WORD = WIDTH + FRAC;

    logic                   write;
    logic signed [WORD-1:0] tau  [6];
    logic signed [WORD-1:0] gain [7];
    logic signed [WORD-1:0] in;
    logic signed [WORD-1:0] out;
    logic                   out_valid;
    logic                   sample_tick;

    modport master (
        output write, tau, gain, in,
        input  out, out_valid, sample_tick
    );

    modport slave (
        input  write, tau, gain, in,
        output out, out_valid, sample_tick
    );
endinterface

// File: rtl/schroeder_reverb_engine.sv
// Schroeder reverberator: four parallel feedback combs, summed into two serial
// all-pass sections, followed by a gain-scaled dry/wet mix. One sample per tick,
// with the tick divided down from the system clock.
module schroeder_reverb_engine #(
    parameter int WIDTH    = 24,
    parameter int FRAC     = 8,
    parameter int MAXDELAY = 2048,
    parameter int CLK_DIV  = 2083
) (
    input logic                      clk,
    input logic                      rst,
    schroeder_reverb_engine_if.slave bus
);
    localparam int WORD = WIDTH + FRAC;
    localparam int AW   = (MAXDELAY > 1) ? $clog2(MAXDELAY) : 1;
    localparam int TW   = $clog2(MAXDELAY + 1);
    localparam int CW   = $clog2(CLK_DIV);
    localparam logic signed [WORD-1:0] ONE    = WORD'(1) << FRAC;
    localparam logic signed [WORD-1:0] MAXD_W = WORD'(MAXDELAY);

    // Fixed-point product: full-width multiply, arithmetic shift, truncate.
    function automatic logic signed [WORD-1:0] mul(input logic signed [WORD-1:0] a,
                                                   input logic signed [WORD-1:0] g);
        logic signed [2*WORD-1:0] p_a;
        logic signed [2*WORD-1:0] p_g;
        logic signed [2*WORD-1:0] p;
        p_a = a;
        p_g = g;
        p   = (p_a * p_g) >>> FRAC;
        return p[WORD-1:0];
    endfunction

    function automatic logic [TW-1:0] clamp_tau(input logic signed [WORD-1:0] t);
        if (t[WORD-1] || t == '0) return TW'(1);
        else if (t > MAXD_W)      return TW'(MAXDELAY);
        else                      return t[TW-1:0];
    endfunction

    function automatic logic signed [WORD-1:0] clamp_gain(input logic signed [WORD-1:0] g);
        if (g[WORD-1])    return '0;
        else if (g > ONE) return ONE;
        else              return g;
    endfunction

    logic [CW-1:0]          r_cnt;
    logic                   w_tick;
    logic                   r_write_d;
    logic [TW-1:0]          r_tau    [6];
    logic signed [WORD-1:0] r_gain   [7];
    logic signed [WORD-1:0] r_gain_s [7];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_wptr_s;
    logic [TW-1:0]          r_fill;
    logic signed [WORD-1:0] r_x;
    logic                   r_v1;
    logic                   r_v2;
    logic signed [WORD-1:0] r_a0;
    logic signed [WORD-1:0] r_out;
    logic                   r_out_valid;

    logic signed [WORD-1:0] w_d     [6];
    logic signed [WORD-1:0] w_wdata [6];
    logic [5:0]             w_we;
    logic signed [WORD-1:0] w_csum;
    logic signed [WORD-1:0] w_a0;
    logic signed [WORD-1:0] w_a1;
    logic signed [WORD-1:0] w_mix;

    assign w_tick          = (r_cnt == CW'(CLK_DIV - 1));
    assign bus.sample_tick = w_tick;
    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;

    // Sample-rate divider: counts 0..CLK_DIV-1 and wraps on the tick.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)         r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end

    // Configuration: latch clamped tau/gain on the rising edge of write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_d <= 1'b0;
            for (int k = 0; k < 6; k++) r_tau[k]  <= TW'(1);
            for (int k = 0; k < 7; k++) r_gain[k] <= '0;
        end else begin
            r_write_d <= bus.write;
            if (bus.write && !r_write_d) begin
                for (int k = 0; k < 6; k++) r_tau[k]  <= clamp_tau(bus.tau[k]);
                for (int k = 0; k < 7; k++) r_gain[k] <= clamp_gain(bus.gain[k]);
            end
        end
    end

    // Write pointer and fill level advance once per tick; the pointer in use
    // for the current sample is held so late-stage writes land in the right slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_wptr_s <= '0;
            r_fill   <= '0;
        end else if (w_tick) begin
            r_wptr   <= (r_wptr == AW'(MAXDELAY - 1)) ? '0 : r_wptr + AW'(1);
            r_wptr_s <= r_wptr;
            if (r_fill != TW'(MAXDELAY)) r_fill <= r_fill + TW'(1);
        end
    end

    // Six delay lines: 0..3 combs, 4..5 all-pass sections.
    for (genvar k = 0; k < 6; k++) begin : g_line
        logic signed [WORD-1:0] r_mem [MAXDELAY];
        logic signed [WORD-1:0] r_rd;
        logic                   r_zero;
        int                     w_addr;

        // Read address is tau entries behind the write pointer, modulo depth.
        always_comb begin
            w_addr = int'(r_wptr) - int'(r_tau[k]);
            if (w_addr < 0) w_addr = w_addr + MAXDELAY;
        end

        // Delay storage write port.
        // NOTE: the delay RAM has no reset so it maps onto block RAM; the fill check hides stale contents.
        always_ff @(posedge clk) begin
            if (w_we[k]) r_mem[r_wptr_s] <= w_wdata[k];
        end

        // Registered read issued on the tick, plus a flag for not-yet-written taps.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd   <= '0;
                r_zero <= 1'b0;
            end else if (w_tick) begin
                r_rd   <= r_mem[w_addr[AW-1:0]];
                r_zero <= (r_tau[k] > r_fill);
            end
        end

        assign w_d[k] = r_zero ? '0 : r_rd;
    end

    // Filter arithmetic: combs and all-pass 0 in stage 1, all-pass 1 and mix in stage 2.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_wdata = '{default: '0};
        w_we    = '0;
        w_csum  = w_d[0] + w_d[1] + w_d[2] + w_d[3];
        for (int i = 0; i < 4; i++) w_wdata[i] = r_x + mul(w_d[i], r_gain_s[i]);
        w_wdata[4] = w_csum + mul(w_d[4], r_gain_s[4]);
        w_a0       = -mul(w_csum, r_gain_s[4])
                     + mul(w_d[4], ONE - mul(r_gain_s[4], r_gain_s[4]));
        w_wdata[5] = r_a0 + mul(w_d[5], r_gain_s[5]);
        w_a1       = -mul(r_a0, r_gain_s[5])
                     + mul(w_d[5], ONE - mul(r_gain_s[5], r_gain_s[5]));
        w_mix      = r_x - mul(w_a1, r_gain_s[6]);
        w_we       = {r_v2, {5{r_v1}}};
    end

    // Sample pipeline: capture on tick, all-pass 0 result after stage 1, output after stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_a0        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < 7; k++) r_gain_s[k] <= '0;
        end else begin
            r_v1        <= w_tick;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            if (w_tick) begin
                r_x      <= bus.in;
                r_gain_s <= r_gain;
            end
            if (r_v1) r_a0  <= w_a0;
            if (r_v2) r_out <= w_mix;
        end
    end
endmodule

// File: tb/tb_schroeder_reverb_engine.sv
// Scoreboard bench for schroeder_reverb_engine: the driver pushes hand-computed
// outputs per sample, the monitor pops and compares on each out_valid.
module tb_schroeder_reverb_engine;
    localparam int WIDTH    = 24;
    localparam int FRAC     = 8;
    localparam int WORD     = WIDTH + FRAC;
    localparam int MAXDELAY = 8;
    localparam int CLK_DIV  = 10;
    localparam int S        = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    schroeder_reverb_engine_if #(.WIDTH(WIDTH), .FRAC(FRAC)) bus ();

    schroeder_reverb_engine #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .MAXDELAY(MAXDELAY),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    exp_q[$];
    int    vec[$];
    int    mon_idx = 0;
    string cur_test = "idle";

    task automatic check(input string name, input logic signed [WORD-1:0] act,
                         input logic signed [WORD-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare each presented output against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", cur_test, mon_idx), bus.out, e);
            mon_idx++;
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            @(negedge clk);
            if (bus.sample_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.in    = '0;
        bus.write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stage_cfg(input int tc, input int gc, input int ga0, input int ga1, input int gm);
        for (int k = 0; k < 4; k++) begin
            bus.tau[k]  = tc;
            bus.gain[k] = gc;
        end
        bus.tau[4]  = 1;
        bus.tau[5]  = 1;
        bus.gain[4] = ga0;
        bus.gain[5] = ga1;
        bus.gain[6] = gm;
    endtask

    task automatic pulse_write();
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * CLK_DIV && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check({name, " drain"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Feed n samples (amp at sample 0, then zeros) and queue vec[] as expected outputs.
    task automatic run_samples(input string name, input int n, input int amp);
        bit ok;
        cur_test = name;
        mon_idx  = 0;
        for (int i = 0; i < n; i++) begin
            wait_tick(ok);
            if (!ok) begin
                check({name, " tick timeout"}, 0, 1);
                return;
            end
            bus.in = (i == 0) ? amp * S : 0;
            exp_q.push_back(vec[i] * S);
        end
        drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        rst       = 1'b1;
        bus.write = 1'b0;
        bus.in    = '0;
        for (int k = 0; k < 6; k++) bus.tau[k]  = '0;
        for (int k = 0; k < 7; k++) bus.gain[k] = '0;

        // Reset state and tick cadence.
        repeat (3) @(negedge clk);
        check("reset out", bus.out, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset sample_tick", bus.sample_tick, 0);
        rst = 1'b0;
        wait_tick(ok);
        check("first tick seen", ok, 1);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            for (int i = 0; i < 4 * CLK_DIV; i++) begin
                @(negedge clk);
                n++;
                if (bus.sample_tick) break;
            end
            check($sformatf("tick period %0d", p), n, CLK_DIV);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) break;
        end
        check("out_valid lag", n, 3);
        check("idle out", bus.out, 0);
        @(negedge clk);
        check("out_valid one cycle", bus.out_valid, 0);

        // Pure delay: out = in - 4*in[n-4].
        do_reset();
        stage_cfg(2, 0, 0, 0, S);
        pulse_write();
        vec = '{1000, 0, 0, 0, -4000, 0, 0, 0};
        run_samples("pure_delay", 8, 1000);

        // Comb decay with gain 0.5.
        do_reset();
        stage_cfg(2, 128, 0, 0, S);
        pulse_write();
        vec = '{1000, 0, 0, 0, -4000, 0, -2000, 0, -1000, 0, -500};
        run_samples("comb_decay", 11, 1000);

        // All-pass 0 with gain 0.5.
        do_reset();
        stage_cfg(1, 0, 128, 0, S);
        pulse_write();
        vec = '{1000, 0, 2000, -3000, -1500, -750, -375};
        run_samples("allpass", 7, 1000);

        // Gain clamping: 300 acts as ONE, negative acts as 0.
        do_reset();
        stage_cfg(2, 0, 0, 0, S);
        bus.gain[0] = 300;
        bus.gain[1] = -100;
        pulse_write();
        vec = '{1000, 0, 0, 0, -4000, 0, -1000, 0, -1000};
        run_samples("gain_clamp", 9, 1000);

        // tau 0 acts as 1.
        do_reset();
        stage_cfg(2, 0, 0, 0, S);
        bus.tau[0] = 0;
        pulse_write();
        vec = '{1000, 0, 0, -1000, -3000, 0};
        run_samples("tau_min", 6, 1000);

        // tau 5000 acts as MAXDELAY.
        do_reset();
        stage_cfg(2, 0, 0, 0, S);
        bus.tau[0] = 5000;
        pulse_write();
        vec = '{1000, 0, 0, 0, -3000, 0, 0, 0, 0, 0, -1000, 0};
        run_samples("tau_max", 12, 1000);

        // write held high: only the rising edge latches.
        do_reset();
        stage_cfg(2, 0, 0, 0, S);
        bus.write = 1'b1;
        repeat (2) @(negedge clk);
        stage_cfg(2, 128, 128, 0, 0);
        vec = '{1000, 0, 0, 0, -4000, 0, 0, 0};
        run_samples("write_held", 8, 1000);
        bus.write = 1'b0;

        // Reset mid-echo: stale delay contents must not reappear.
        do_reset();
        stage_cfg(2, 128, 0, 0, S);
        pulse_write();
        vec = '{1000, 0, 0, 0, -4000};
        run_samples("pre_reset", 5, 1000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset out", bus.out, 0);
        check("mid reset out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        stage_cfg(MAXDELAY, 0, 0, 0, S);
        pulse_write();
        vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_samples("no_stale", 10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/schroeder_reverb_engine.md
Name: schroeder_reverb_engine

Overview:
- Single-clock Schroeder reverberator datapath for the audio filter chain: four parallel feedback comb filters, summed, feed two serial all-pass filters, then a gain-scaled output mix.
- Includes its own sample-rate tick generator (divided from the system clock) and synchronous configuration registers.
- Processes one sample per tick.
- All data is signed fixed point: WORD = WIDTH+FRAC bits, FRAC fractional bits; ONE = 1<<FRAC.

Parameters:
- WIDTH, 24, integer bits of a sample.
- FRAC, 8, fractional bits.
- MAXDELAY, 2048, delay-line depth per filter, in samples.
- CLK_DIV, 2083, system clocks per sample tick (100 MHz / 48 kHz); must be >= 8.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- write  in  1  configuration strobe; config latched on its rising edge, detected at clk.
- tau  in  6 x WORD  delays in samples (integer): [0..3] combs, [4..5] all-pass 0/1.
- gain  in  7 x WORD  fixed-point gains: [0..3] combs, [4..5] all-pass, [6] mix.
- in  in  WORD  input sample, captured on tick.
- out  out  WORD  output sample (registered).
- out_valid  out  1  one-cycle pulse when out updates.
- sample_tick  out  1  one-cycle sample-rate pulse.

Behaviour:
- Tick: counter 0..CLK_DIV-1; sample_tick=1 when counter==CLK_DIV-1, then wraps to 0. First tick occurs CLK_DIV cycles after rst deasserts.
- Reset values:
  - counter, out, out_valid, write-edge register, delay-line pointers, fill counters and pipeline registers all 0.
  - tau registers 1; gain registers 0.
  - Delay RAM contents are not cleared.
- Config:
  - Rising edge of write (write=1 and previous write=0) latches all tau and gain values in that cycle.
  - Each gain is clamped to [0, ONE].
  - Each tau is clamped to [1, MAXDELAY].
  - New values take effect from the next tick; delay contents are preserved.
- Mul(a,g) = (a*g) computed at 2*WORD bits, arithmetic shift right FRAC, truncated to WORD. All add/sub is WORD two's-complement wrap.
- Delay read: per line, d = entry written tau ticks ago (addr = wptr - tau mod MAXDELAY). If tau > fill (entries written since reset, saturating at MAXDELAY), d = 0.
- Comb i: d = delayed value; w = x + Mul(d, g_i); write w; output c_i = d.
- csum = c0+c1+c2+c3.
- All-pass k (input x, gain g):
  - v = x + Mul(d, g); write v.
  - a = -Mul(x, g) + Mul(d, ONE - Mul(g, g)).
  - All-pass 0 input = csum; all-pass 1 input = a0.
- Mix: out = in - Mul(a1, gain[6]).
- Pipeline, tick at cycle T:
  - T: capture in, issue all six reads.
  - T+1: comb writes, csum, all-pass 0 result.
  - T+2: all-pass 1.
  - T+3: out registered and out_valid=1.
  - Write pointers advance once per tick; fill counters increment once per tick.
- Ticks arriving while rst=1 are ignored.
- write edge coinciding with a tick: the old config is used for that sample.
- Reset mid-operation: pipeline is aborted, out=0, fill counters 0, so stale echoes read as 0.

Test Plan:
(FRAC=8, values in integer units, raw = value*256; gain[6]=ONE unless noted; in = 1000 at sample 0, else 0.)
- Reset/tick: hold rst 3 cycles, release -> out=0, out_valid=0; sample_tick pulses every CLK_DIV cycles; out_valid exactly 3 cycles after each tick.
- Pure delay: comb tau=2, gain=0; all-pass tau=1, gain=0 -> out samples 0..4 = 1000, 0, 0, 0, -4000.
- Comb decay: same setup but comb gain=128 -> out at samples 4, 6, 8 = -4000, -2000, -1000; samples 5, 7 = 0.
- All-pass: comb tau=1 gain=0; all-pass 0 tau=1 gain=128; all-pass 1 tau=1 gain=0 -> out samples 2, 3, 4 = 2000, -3000, -1500.
- Clamping: gain[0]=300 -> behaves as 256; tau[0]=0 -> acts as 1; tau[0]=5000 -> acts as MAXDELAY; write held high -> only one latch.
- Reset mid-echo: during the comb-decay test, pulse rst after sample 4 -> out=0; after new ticks with in=0, out stays 0 (no stale echo).
